// File: rtl/parity_frame_checker.sv
// parity_frame_checker: deserialises LSB-first DATA_W-bit serial frames plus a parity bit and reports word, parity error and aborts; optional PARITY_ERR_COUNT_EN adds a saturating error counter
module parity_frame_checker #(
  parameter int DATA_W  = 8,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in,
  input  logic              io_in_valid,
  input  logic              io_sof,
  output logic [DATA_W-1:0] io_data,
  output logic              io_valid,
  output logic              io_err,
  output logic              io_abort,
  output logic              io_busy
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [15:0]       io_err_count
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              par, par_n;
  logic [DATA_W-1:0] shift, shift_n, data_n;
  logic              valid_n, err_n, abort_n;
  // next-state: sof beats always restart a frame; data beats fill the shift register; the parity beat closes the frame
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    par_n   = par;
    shift_n = shift;
    data_n  = io_data;
    err_n   = io_err;
    valid_n = 1'b0;
    abort_n = 1'b0;
    if (io_in_valid && io_sof) begin
      abort_n = state != IDLE;
      shift_n = DATA_W'(io_in);
      par_n   = io_in;
      cnt_n   = CW'(1);
      state_n = DATA;
    end else if (io_in_valid && state == DATA) begin
      shift_n = shift | (DATA_W'(io_in) << cnt);
      par_n   = par ^ io_in;
      cnt_n   = cnt + CW'(1);
      state_n = (cnt_n == CW'(DATA_W)) ? PAR : DATA;
    end else if (io_in_valid && state == PAR) begin
      data_n  = shift;
      err_n   = par ^ io_in ^ ODD_PAR;
      valid_n = 1'b1;
      cnt_n   = '0;
      par_n   = 1'b0;
      state_n = IDLE;
    end
  end
  // state and output registers; reset drops any partial frame without a pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      par      <= 1'b0;
      shift    <= '0;
      io_data  <= '0;
      io_valid <= 1'b0;
      io_err   <= 1'b0;
      io_abort <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      par      <= par_n;
      shift    <= shift_n;
      io_data  <= data_n;
      io_valid <= valid_n;
      io_err   <= err_n;
      io_abort <= abort_n;
    end
  end
  assign io_busy = state != IDLE;
`ifdef PARITY_ERR_COUNT_EN
  // counts reported frames with bad parity, visible alongside their io_valid pulse; saturates instead of wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) io_err_count <= '0;
    else if (valid_n && err_n && io_err_count != 16'hFFFF) io_err_count <= io_err_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: scoreboard bench driving an even- and an odd-parity checker with identical serial stimulus
module tb_parity_frame_checker;
  logic clock = 1'b0, reset = 1'b1, io_in = 1'b0, io_in_valid = 1'b0, io_sof = 1'b0;
  logic [7:0] e_data, o_data;
  logic e_valid, e_err, e_abort, e_busy, o_valid, o_err, o_abort, o_busy;
`ifdef PARITY_ERR_COUNT_EN
  logic [15:0] e_cnt, o_cnt;
`endif
  int asserts = 0, fails = 0, valid_cnt = 0, abort_cnt = 0;
  typedef struct packed {logic [7:0] d; logic ee; logic eo;} exp_t;
  exp_t q[$];
  exp_t x;
  always #5 clock = ~clock;
  parity_frame_checker #(.DATA_W(8), .ODD_PAR(1'b0)) dut_e (
    .clock(clock), .reset(reset), .io_in(io_in), .io_in_valid(io_in_valid), .io_sof(io_sof),
    .io_data(e_data), .io_valid(e_valid), .io_err(e_err), .io_abort(e_abort), .io_busy(e_busy)
`ifdef PARITY_ERR_COUNT_EN
    , .io_err_count(e_cnt)
`endif
  );
  parity_frame_checker #(.DATA_W(8), .ODD_PAR(1'b1)) dut_o (
    .clock(clock), .reset(reset), .io_in(io_in), .io_in_valid(io_in_valid), .io_sof(io_sof),
    .io_data(o_data), .io_valid(o_valid), .io_err(o_err), .io_abort(o_abort), .io_busy(o_busy)
`ifdef PARITY_ERR_COUNT_EN
    , .io_err_count(o_cnt)
`endif
  );
  // scoreboard monitor: every io_valid pulse must match the oldest pushed expectation
  always @(negedge clock) begin
    if (e_abort) abort_cnt++;
    if (e_valid) begin
      valid_cnt++;
      asserts++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid got data=%h err=%b, required no pulse", e_data, e_err);
      end else begin
        x = q.pop_front();
        if ({e_data, e_err} !== {x.d, x.ee}) begin
          fails++;
          $display("FAIL even_frame got data=%h err=%b, required data=%h err=%b", e_data, e_err, x.d, x.ee);
        end
        asserts++;
        if ({o_valid, o_data, o_err} !== {1'b1, x.d, x.eo}) begin
          fails++;
          $display("FAIL odd_frame got valid=%b data=%h err=%b, required valid=1 data=%h err=%b", o_valid, o_data, o_err, x.d, x.eo);
        end
      end
    end
  end
  task automatic send_beat(input logic b, input logic s);
    @(negedge clock);
    io_in = b;
    io_in_valid = 1'b1;
    io_sof = s;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      io_in = 1'b0;
      io_in_valid = 1'b0;
      io_sof = 1'b0;
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_beat(d[i], i == 0);
      if (gap > 0) idle(gap);
    end
    q.push_back(exp_t'{d, (^d) ^ p, ~((^d) ^ p)});
    send_beat(p, 1'b0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d frames outstanding, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    asserts++;
    if ({e_data, e_valid, e_err, e_abort, e_busy, o_data, o_valid, o_err, o_abort, o_busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got even=%h/%b%b%b%b odd=%h/%b%b%b%b, required all 0", e_data, e_valid, e_err, e_abort, e_busy, o_data, o_valid, o_err, o_abort, o_busy);
    end
`ifdef PARITY_ERR_COUNT_EN
    asserts++;
    if (e_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_err_count got %0d, required 0", e_cnt);
    end
`endif
    reset = 1'b0;
  endtask
  task automatic test_good_frame();
    int v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 0);
    asserts++;
    if ({e_busy, e_valid} !== 2'b10) begin
      fails++;
      $display("FAIL good_before_parity got busy=%b valid=%b, required busy=1 valid=0", e_busy, e_valid);
    end
    idle(1);
    asserts++;
    if ({e_valid, e_busy} !== 2'b10) begin
      fails++;
      $display("FAIL good_latency got valid=%b busy=%b, required valid=1 busy=0", e_valid, e_busy);
    end
    idle(1);
    asserts++;
    if ({e_valid, e_data} !== {1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL good_pulse_hold got valid=%b data=%h, required valid=0 data=a5", e_valid, e_data);
    end
    drain();
    asserts++;
    if (valid_cnt - v0 !== 1) begin
      fails++;
      $display("FAIL good_count got %0d pulses, required 1", valid_cnt - v0);
    end
  endtask
  task automatic test_bad_parity();
`ifdef PARITY_ERR_COUNT_EN
    logic [15:0] c0 = e_cnt;
`endif
    send_frame(8'hA5, 1'b1, 0);
    idle(2);
    drain();
`ifdef PARITY_ERR_COUNT_EN
    asserts++;
    if (e_cnt !== c0 + 16'd1) begin
      fails++;
      $display("FAIL err_count got %0d, required %0d", e_cnt, c0 + 16'd1);
    end
`endif
  endtask
  task automatic test_gaps();
    int v0 = valid_cnt;
    send_frame(8'h01, 1'b1, 3);
    asserts++;
    if (e_busy !== 1'b1) begin
      fails++;
      $display("FAIL gaps_busy got %b, required 1", e_busy);
    end
    idle(2);
    drain();
    asserts++;
    if (valid_cnt - v0 !== 1) begin
      fails++;
      $display("FAIL gaps_count got %0d pulses, required 1", valid_cnt - v0);
    end
  endtask
  task automatic test_abort();
    int v0 = valid_cnt, a0 = abort_cnt;
    send_beat(1'b1, 1'b1);
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 0);
    idle(2);
    drain();
    asserts++;
    if (abort_cnt - a0 !== 1) begin
      fails++;
      $display("FAIL abort_pulse got %0d cycles, required 1", abort_cnt - a0);
    end
    asserts++;
    if (valid_cnt - v0 !== 1) begin
      fails++;
      $display("FAIL abort_valid_count got %0d pulses, required 1", valid_cnt - v0);
    end
  endtask
  task automatic test_reset_mid();
    int v0 = valid_cnt;
    send_beat(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    io_in_valid = 1'b0;
    #1;
    asserts++;
    if ({e_busy, o_busy} !== 2'b00) begin
      fails++;
      $display("FAIL async_reset_busy got %b%b, required 00", e_busy, o_busy);
    end
    repeat (2) @(negedge clock);
    asserts++;
    if ({e_data, e_valid, e_err, e_abort, e_busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs got %h/%b%b%b%b, required all 0", e_data, e_valid, e_err, e_abort, e_busy);
    end
    reset = 1'b0;
    send_frame(8'hFF, 1'b0, 0);
    idle(2);
    drain();
    asserts++;
    if (valid_cnt - v0 !== 1) begin
      fails++;
      $display("FAIL mid_reset_count got %0d pulses, required 1", valid_cnt - v0);
    end
  endtask
  task automatic test_back_to_back();
    int v0 = valid_cnt, a0 = abort_cnt;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'h00, 1'b0, 0);
    send_frame(8'h5A, 1'b1, 0);
    idle(2);
    drain();
    asserts++;
    if (valid_cnt - v0 !== 3) begin
      fails++;
      $display("FAIL b2b_count got %0d pulses, required 3", valid_cnt - v0);
    end
    asserts++;
    if (abort_cnt - a0 !== 0) begin
      fails++;
      $display("FAIL b2b_abort got %0d aborts, required 0", abort_cnt - a0);
    end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
